aes_rcon_gen: RTL and testbench

//  Round-constant sequencer for the AES key-expansion datapath. Supports AES-128/192/256

---
 rtl/aes_rcon_gen.sv | 137 +++++++++++++
 tb/tb_aes_rcon_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_rcon_gen.sv
// AES round-constant sequencer for the key-expansion datapath.
// Walks the rcon sequence forward (0x01 upward, xtime) or in reverse
// (final constant downward, inverse xtime) for AES-128/192/256 schedules.
// The rcon byte sits in the top byte of the output word; all other bits are zero.
module aes_rcon_gen #(
    parameter int unsigned W      = 32,
    parameter bit          INV_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [1:0]   klen,
    input  logic         dir,
    input  logic         adv,
    output logic [W-1:0] rcon,
    output logic [3:0]   rnd_idx,
    output logic         valid,
    output logic         last,
    output logic         done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  byte_q,  byte_d;
    logic [3:0]  idx_q,   idx_d;
    logic [3:0]  len_q,   len_d;
    logic        dir_q,   dir_d;
    logic        valid_q, valid_d;
    logic        last_q,  last_d;
    logic        done_q,  done_d;

    logic [3:0]  kld_len;
    logic        kld_dir;
    logic [3:0]  idx_inc;

    // GF(2^8) multiply by x, reduction polynomial 0x11b
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by x^-1 (inverse of xtime)
    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
    endfunction

    // Decode walk length and effective direction from the load-time inputs
    always_comb begin
        unique case (klen)
            2'd1:    kld_len = 4'd8;
            2'd2:    kld_len = 4'd7;
            default: kld_len = 4'd10;
        endcase
        kld_dir = INV_EN ? dir : 1'b0;
        idx_inc = idx_q + 4'd1;
    end

    // Next-state logic: kld has priority over adv in every state
    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        idx_d   = idx_q;
        len_d   = len_q;
        dir_d   = dir_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;

        if (kld) begin
            state_d = ST_RUN;
            idx_d   = '0;
            len_d   = kld_len;
            dir_d   = kld_dir;
            valid_d = 1'b1;
            last_d  = (kld_len == 4'd1);
            if (!kld_dir) begin
                byte_d = 8'h01;
            end else begin
                unique case (kld_len)
                    4'd8:    byte_d = 8'h80;
                    4'd7:    byte_d = 8'h40;
                    default: byte_d = 8'h36;
                endcase
            end
        end else if (adv && state_q == ST_RUN && valid_q) begin
            if (last_q) begin
                state_d = ST_DONE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                idx_d  = idx_inc;
                byte_d = dir_q ? inv_xtime(byte_q) : xtime(byte_q);
                last_d = (idx_inc == (len_q - 4'd1));
            end
        end
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            byte_q  <= '0;
            idx_q   <= '0;
            len_q   <= 4'd10;
            dir_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            dir_q   <= dir_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    // Place the rcon byte in the top byte of the output word
    always_comb begin
        rcon            = '0;
        rcon[W-1 -: 8]  = byte_q;
    end

    assign rnd_idx = idx_q;
    assign valid   = valid_q;
    assign last    = last_q;
    assign done    = done_q;

endmodule

// File: tb/tb_aes_rcon_gen.sv
// Bench for aes_rcon_gen: default instance, a W=128 instance and an INV_EN=0
// instance share one stimulus stream and are checked against a sequence model.
module tb_aes_rcon_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         kld;
    logic [1:0]   klen;
    logic         dir;
    logic         adv;

    logic [31:0]  a_rcon;
    logic [3:0]   a_idx;
    logic         a_valid, a_last, a_done;
    logic [127:0] b_rcon;
    logic [3:0]   b_idx;
    logic         b_valid, b_last, b_done;
    logic [31:0]  c_rcon;
    logic [3:0]   c_idx;
    logic         c_valid, c_last, c_done;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    // Model state: index 0 models the reverse-capable instances, index 1 the forward-only one
    bit          m_run[2];
    bit          m_started[2];
    bit          m_dir[2];
    bit          m_done[2];
    int unsigned m_n[2];
    int unsigned m_idx[2];

    aes_rcon_gen #(.W(32), .INV_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .kld(kld), .klen(klen), .dir(dir), .adv(adv),
        .rcon(a_rcon), .rnd_idx(a_idx), .valid(a_valid), .last(a_last), .done(a_done)
    );

    aes_rcon_gen #(.W(128), .INV_EN(1'b1)) dut_b (
        .clk(clk), .rst(rst), .kld(kld), .klen(klen), .dir(dir), .adv(adv),
        .rcon(b_rcon), .rnd_idx(b_idx), .valid(b_valid), .last(b_last), .done(b_done)
    );

    aes_rcon_gen #(.W(32), .INV_EN(1'b0)) dut_c (
        .clk(clk), .rst(rst), .kld(kld), .klen(klen), .dir(dir), .adv(adv),
        .rcon(c_rcon), .rnd_idx(c_idx), .valid(c_valid), .last(c_last), .done(c_done)
    );

    always #5 clk = ~clk;

    // k-th forward round constant: 0x01 doubled k times modulo x^8+x^4+x^3+x+1
    function automatic int unsigned fwd_const(input int unsigned k);
        int unsigned v = 1;
        for (int unsigned j = 0; j < k; j++) begin
            v = v * 2;
            if (v > 255) v = v ^ 32'h11b;
        end
        return v;
    endfunction

    function automatic int unsigned walk_len(input logic [1:0] kl);
        if (kl == 2'd1) return 8;
        if (kl == 2'd2) return 7;
        return 10;
    endfunction

    // Expected byte: reverse walk is the forward list read back to front
    function automatic logic [7:0] exp_byte(input int c);
        int unsigned k;
        if (!m_started[c]) return 8'h00;
        k = m_dir[c] ? (m_n[c] - 1 - m_idx[c]) : m_idx[c];
        return 8'(fwd_const(k));
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_run[c] = 0; m_started[c] = 0; m_dir[c] = 0; m_done[c] = 0;
            m_n[c] = 10; m_idx[c] = 0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            if (kld) begin
                m_run[c] = 1; m_started[c] = 1; m_idx[c] = 0; m_done[c] = 0;
                m_n[c]   = walk_len(klen);
                m_dir[c] = (c == 0) ? dir : 1'b0;
            end else if (adv && m_run[c]) begin
                if (m_idx[c] == m_n[c] - 1) begin
                    m_run[c] = 0; m_done[c] = 1;
                end else begin
                    m_idx[c]++; m_done[c] = 0;
                end
            end else begin
                m_done[c] = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [7:0] e0, e1;
        bit l0, l1;
        e0 = exp_byte(0);
        e1 = exp_byte(1);
        l0 = m_run[0] && (m_idx[0] == m_n[0] - 1);
        l1 = m_run[1] && (m_idx[1] == m_n[1] - 1);
        chk("a.rcon",  128'(a_rcon),  128'({e0, 24'h0}));
        chk("a.idx",   128'(a_idx),   128'(m_idx[0]));
        chk("a.valid", 128'(a_valid), 128'(m_run[0]));
        chk("a.last",  128'(a_last),  128'(l0));
        chk("a.done",  128'(a_done),  128'(m_done[0]));
        chk("b.rcon",  b_rcon,        {e0, 120'h0});
        chk("b.valid", 128'(b_valid), 128'(m_run[0]));
        chk("c.rcon",  128'(c_rcon),  128'({e1, 24'h0}));
        chk("c.idx",   128'(c_idx),   128'(m_idx[1]));
        chk("c.valid", 128'(c_valid), 128'(m_run[1]));
        chk("c.last",  128'(c_last),  128'(l1));
        chk("c.done",  128'(c_done),  128'(m_done[1]));
    endtask

    task automatic drive(input logic k, input logic [1:0] kl, input logic d, input logic a);
        kld = k; klen = kl; dir = d; adv = a;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run_walk(input logic [1:0] kl, input logic d, input int unsigned advs);
        drive(1'b1, kl, d, 1'b0);
        step();
        drive(1'b0, kl, d, 1'b1);
        repeat (advs) step();
        drive(1'b0, kl, d, 1'b0);
        step();
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        #3;
        check_all();
        #4 rst = 1'b0;

        // adv while idle is ignored
        drive(1'b0, 2'd0, 1'b0, 1'b1);
        step();

        // forward and reverse walks for every key length, past the done pulse
        run_walk(2'd0, 1'b0, 12);
        run_walk(2'd0, 1'b1, 12);
        run_walk(2'd1, 1'b0, 10);
        run_walk(2'd2, 1'b1, 9);
        run_walk(2'd3, 1'b0, 12);
        run_walk(2'd1, 1'b1, 10);

        // kld and adv together at rnd_idx=4: restart wins
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 2'd0, 1'b0, 1'b1);
        repeat (4) step();
        drive(1'b1, 2'd0, 1'b0, 1'b1);
        step();
        // klen/dir wobble mid-walk, then adv in DONE
        repeat (14) begin
            drive(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
            step();
        end

        // asynchronous reset mid-cycle at rnd_idx=5
        drive(1'b1, 2'd0, 1'b1, 1'b0);
        step();
        drive(1'b0, 2'd0, 1'b1, 1'b1);
        repeat (5) step();
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all();
        #1 rst = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 1'b1);
        repeat (2) step();

        // randomized traffic
        repeat (400) begin
            drive(1'($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
